// File: rtl/alu_iter_if.sv
// alu_iter_if: control/status bundle between the controller FSM and alu_iter.
//   OP   : common operand from the shared data bus
//   FN   : function select
//   Ain  : load A from OP
//   Gin  : compute A FN OP into G and the flags
//   Gout : enable the RES driver onto the shared bus
//   Busy : iterative shift in progress
//   Z/N/C/V : registered status flags
// RES is a tri-state port on the ALU itself, so it resolves directly on the bus.
interface alu_iter_if #(
  parameter int W = 10
);
  logic [W-1:0] OP;
  logic [3:0]   FN;
  logic         Ain;
  logic         Gin;
  logic         Gout;
  logic         Busy;
  logic         Z;
  logic         N;
  logic         C;
  logic         V;

  modport master (output OP, FN, Ain, Gin, Gout, input  Busy, Z, N, C, V);
  modport slave  (input  OP, FN, Ain, Gin, Gout, output Busy, Z, N, C, V);
endinterface

// File: rtl/alu_iter.sv
// alu_iter: staged ALU with an A operand register, a G result register,
// registered Z/N/C/V flags, a tri-state result driver and an optional
// one-bit-per-cycle shifter.
//   CLKb : clock, all state updates on the falling edge
//   Rst  : synchronous active-high reset
//   bus  : alu_iter_if slave (OP, FN, Ain, Gin, Gout in; Busy, Z, N, C, V out)
//   RES  : G when Gout=1, high-impedance otherwise
module alu_iter #(
  parameter int W          = 10,
  parameter int IMMW       = 6,
  parameter int SHIFT_ITER = 1
) (
  input  logic         CLKb,
  input  logic         Rst,
  alu_iter_if.slave    bus,
  output wire  [W-1:0] RES
);
  localparam int AW = $clog2(W + 1);

  typedef enum logic {IDLE, SHIFT} state_t;

  state_t         r_state;
  logic [W-1:0]   r_A, r_G, r_S;
  logic [AW-1:0]  r_cnt;
  logic [3:0]     r_fn;
  logic           r_busy, r_Z, r_N, r_C, r_V;

  logic [AW-1:0]  w_amt;
  logic [W-1:0]   w_b, w_f, w_step_s;
  logic [W:0]     w_sum, w_dif, w_lsl, w_lsr, w_asr;
  logic           w_c, w_v, w_step_c, w_is_shift, w_start;

  // Shift amounts saturate at W, which already yields the fully shifted result.
  assign w_amt = ({1'b0, bus.OP} >= (W+1)'(W)) ? AW'(W) : AW'(bus.OP);

  // ADDI/SUBI take the zero-extended immediate field of OP.
  assign w_b   = (bus.FN == 4'd12 || bus.FN == 4'd13) ? W'(bus.OP[IMMW-1:0]) : bus.OP;
  assign w_sum = {1'b0, r_A} + {1'b0, w_b};
  assign w_dif = {1'b0, r_A} - {1'b0, w_b};

  // One guard bit on the far side of each shift catches the last bit shifted
  // out; it stays 0 for a zero amount.
  assign w_lsl = {1'b0, r_A} << w_amt;
  assign w_lsr = {r_A, 1'b0} >> w_amt;
  assign w_asr = $signed({r_A, 1'b0}) >>> w_amt;

  assign w_is_shift = (bus.FN == 4'd9) || (bus.FN == 4'd10) || (bus.FN == 4'd11);
  assign w_start    = (SHIFT_ITER != 0) && w_is_shift && (w_amt != '0);

  always_comb begin
    w_f = '0;
    w_c = 1'b0;
    w_v = 1'b0;
    case (bus.FN)
      4'd0, 4'd1: w_f = bus.OP;
      4'd2, 4'd12: begin
        w_f = w_sum[W-1:0];
        w_c = w_sum[W];
        w_v = (r_A[W-1] == w_b[W-1]) && (w_sum[W-1] != r_A[W-1]);
      end
      4'd3, 4'd13: begin
        w_f = w_dif[W-1:0];
        w_c = ~w_dif[W];  // no borrow
        w_v = (r_A[W-1] != w_b[W-1]) && (w_dif[W-1] != r_A[W-1]);
      end
      4'd4: begin
        w_f = -bus.OP;
        w_c = (bus.OP == '0);
        w_v = (bus.OP == {1'b1, {(W-1){1'b0}}});
      end
      4'd5:  w_f = ~bus.OP;
      4'd6:  w_f = r_A & bus.OP;
      4'd7:  w_f = r_A | bus.OP;
      4'd8:  w_f = r_A ^ bus.OP;
      4'd9:  begin w_f = w_lsl[W-1:0]; w_c = w_lsl[W]; end
      4'd10: begin w_f = w_lsr[W:1];   w_c = w_lsr[0]; end
      4'd11: begin w_f = w_asr[W:1];   w_c = w_asr[0]; end
      default: ;
    endcase
  end

  // One-bit step of the iterative shifter on its private copy S.
  always_comb begin
    w_step_s = r_S;
    w_step_c = 1'b0;
    case (r_fn)
      4'd9:    begin w_step_s = {r_S[W-2:0], 1'b0};      w_step_c = r_S[W-1]; end
      4'd10:   begin w_step_s = {1'b0, r_S[W-1:1]};      w_step_c = r_S[0];   end
      4'd11:   begin w_step_s = {r_S[W-1], r_S[W-1:1]};  w_step_c = r_S[0];   end
      default: ;
    endcase
  end

  always_ff @(negedge CLKb) begin
    if (Rst) begin
      r_state <= IDLE;
      r_A     <= '0;
      r_G     <= '0;
      r_S     <= '0;
      r_cnt   <= '0;
      r_fn    <= '0;
      r_busy  <= 1'b0;
      r_Z     <= 1'b0;
      r_N     <= 1'b0;
      r_C     <= 1'b0;
      r_V     <= 1'b0;
    end else begin
      // A stays loadable during a shift; the shifter works on r_S.
      if (bus.Ain) r_A <= bus.OP;
      case (r_state)
        IDLE: begin
          if (bus.Gin) begin
            if (w_start) begin
              r_S     <= r_A;
              r_cnt   <= w_amt;
              r_fn    <= bus.FN;
              r_busy  <= 1'b1;
              r_state <= SHIFT;
            end else if (bus.FN <= 4'd13) begin
              r_G <= w_f;
              r_Z <= (w_f == '0);
              r_N <= w_f[W-1];
              r_C <= w_c;
              r_V <= w_v;
            end
          end
        end
        SHIFT: begin
          // Gin is ignored here; only the final step commits G and flags.
          r_S   <= w_step_s;
          r_cnt <= r_cnt - AW'(1);
          if (r_cnt == AW'(1)) begin
            r_G     <= w_step_s;
            r_Z     <= (w_step_s == '0);
            r_N     <= w_step_s[W-1];
            r_C     <= w_step_c;
            r_V     <= 1'b0;
            r_busy  <= 1'b0;
            r_state <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign bus.Busy = r_busy;
  assign bus.Z    = r_Z;
  assign bus.N    = r_N;
  assign bus.C    = r_C;
  assign bus.V    = r_V;
  assign RES      = bus.Gout ? r_G : 'z;
endmodule

// File: tb/tb_alu_iter.sv
// tb_alu_iter: directed scenarios plus randomized ops for alu_iter, with an
// iterative instance (dut1) and a barrel instance (dut0) driven in lockstep.
module tb_alu_iter;
  localparam int W = 10, IMMW = 6, MASK = (1 << W) - 1;

  logic CLKb = 1'b0;
  logic Rst  = 1'b1;
  always #5 CLKb = ~CLKb;

  alu_iter_if #(.W(W)) b1();
  alu_iter_if #(.W(W)) b0();
  wire [W-1:0] res1, res0;

  alu_iter #(.W(W), .IMMW(IMMW), .SHIFT_ITER(1)) dut1 (.CLKb(CLKb), .Rst(Rst), .bus(b1), .RES(res1));
  alu_iter #(.W(W), .IMMW(IMMW), .SHIFT_ITER(0)) dut0 (.CLKb(CLKb), .Rst(Rst), .bus(b0), .RES(res0));

  int n_chk = 0, n_pass = 0;
  int mA, mG;
  bit mZ, mN, mC, mV;

  task automatic drive(input bit ain, input bit gin, input int fn, input int op);
    b1.Ain = ain; b0.Ain = ain;
    b1.Gin = gin; b0.Gin = gin;
    b1.FN = 4'(fn); b0.FN = 4'(fn);
    b1.OP = W'(op); b0.OP = W'(op);
  endtask

  task automatic set_gout(input bit g);
    b1.Gout = g; b0.Gout = g;
  endtask

  // Active edge is the falling one; inputs change and outputs are sampled 1 later.
  task automatic tick;
    @(negedge CLKb); #1;
  endtask

  task automatic load_a(input int v);
    drive(1, 0, 0, v); tick; drive(0, 0, 0, 0);
  endtask

  task automatic gin_op(input int fn, input int op);
    drive(0, 1, fn, op); tick; drive(0, 0, 0, 0);
  endtask

  // Reference: result and C/V straight from the arithmetic definitions.
  function automatic void ref_op(input int fn, input int a, input int op,
                                 output int f, output bit c, output bit v);
    int b, sa, sb, r, n, hi, lo;
    hi = (1 << (W-1)) - 1;
    lo = -(1 << (W-1));
    b  = (fn == 12 || fn == 13) ? (op & ((1 << IMMW) - 1)) : op;
    sa = (a >= (1 << (W-1))) ? a - (1 << W) : a;
    sb = (b >= (1 << (W-1))) ? b - (1 << W) : b;
    n  = (op > W) ? W : op;
    f = 0; c = 0; v = 0;
    case (fn)
      0, 1: f = op;
      2, 12: begin r = a + b; f = r & MASK; c = (r > MASK); v = (sa + sb > hi) || (sa + sb < lo); end
      3, 13: begin f = (a - b) & MASK; c = (a >= b); v = (sa - sb > hi) || (sa - sb < lo); end
      4: begin f = (0 - op) & MASK; c = (op == 0); v = (op == (1 << (W-1))); end
      5: f = (~op) & MASK;
      6: f = a & op;
      7: f = a | op;
      8: f = a ^ op;
      9:  begin f = (a << n) & MASK; c = (n > 0) && (((a >> (W - n)) & 1) != 0); end
      10: begin f = a >> n;          c = (n > 0) && (((a >> (n - 1)) & 1) != 0); end
      11: begin f = (sa >>> n) & MASK; c = (n > 0) && (((sa >>> (n - 1)) & 1) != 0); end
      default: f = -1;
    endcase
  endfunction

  task automatic test_reset;
    set_gout(1); Rst = 1; drive(0, 0, 0, 0); tick; tick; Rst = 0;
    n_chk++;
    if (res1 !== '0 || res0 !== '0) $display("FAIL reset_res got %h/%h want 000", res1, res0);
    else n_pass++;
    n_chk++;
    if ({b1.Busy, b1.Z, b1.N, b1.C, b1.V} !== 5'b0 || {b0.Busy, b0.Z, b0.N, b0.C, b0.V} !== 5'b0)
      $display("FAIL reset_flags got %b/%b want 00000", {b1.Busy, b1.Z, b1.N, b1.C, b1.V}, {b0.Busy, b0.Z, b0.N, b0.C, b0.V});
    else n_pass++;
  endtask

  task automatic test_add;
    load_a(5); gin_op(2, 3);
    n_chk++;
    if (res1 !== 10'h008 || {b1.Z, b1.N, b1.C, b1.V} !== 4'b0000)
      $display("FAIL add_basic got %h %b want 008 0000", res1, {b1.Z, b1.N, b1.C, b1.V});
    else n_pass++;
    set_gout(0); #1;
    n_chk++;
    if (res1 === 10'h008) $display("FAIL res_release got %h want undriven", res1);
    else n_pass++;
    set_gout(1); #1;
    load_a(10'h1FF); gin_op(2, 1);
    n_chk++;
    if (res1 !== 10'h200 || {b1.Z, b1.N, b1.C, b1.V} !== 4'b0101)
      $display("FAIL add_ovf got %h %b want 200 0101", res1, {b1.Z, b1.N, b1.C, b1.V});
    else n_pass++;
    load_a(10'h3FF); gin_op(2, 1);
    n_chk++;
    if (res1 !== 10'h000 || {b1.Z, b1.N, b1.C, b1.V} !== 4'b1010)
      $display("FAIL add_carry got %h %b want 000 1010", res1, {b1.Z, b1.N, b1.C, b1.V});
    else n_pass++;
  endtask

  task automatic test_sub_inv;
    load_a(3); gin_op(3, 5);
    n_chk++;
    if (res1 !== 10'h3FE || {b1.Z, b1.N, b1.C, b1.V} !== 4'b0100)
      $display("FAIL sub_borrow got %h %b want 3fe 0100", res1, {b1.Z, b1.N, b1.C, b1.V});
    else n_pass++;
    gin_op(4, 10'h200);
    n_chk++;
    if (res1 !== 10'h200 || {b1.Z, b1.N, b1.C, b1.V} !== 4'b0101)
      $display("FAIL inv_min got %h %b want 200 0101", res1, {b1.Z, b1.N, b1.C, b1.V});
    else n_pass++;
  endtask

  task automatic test_asr_iter;
    int cnt;
    load_a(10'h200); gin_op(11, 3);
    n_chk++;
    if (res0 !== 10'h3C0 || {b0.Z, b0.N, b0.C, b0.V} !== 4'b0100 || b0.Busy !== 1'b0)
      $display("FAIL asr_barrel got %h %b busy=%b want 3c0 0100 0", res0, {b0.Z, b0.N, b0.C, b0.V}, b0.Busy);
    else n_pass++;
    cnt = 0;
    while (b1.Busy && cnt < 40) begin
      cnt++;
      if (cnt == 1) drive(0, 1, 2, 1); else drive(0, 0, 0, 0);
      tick;
    end
    drive(0, 0, 0, 0);
    n_chk++;
    if (cnt !== 3) $display("FAIL asr_busy_cycles got %0d want 3", cnt);
    else n_pass++;
    n_chk++;
    if (res1 !== 10'h3C0 || {b1.Z, b1.N, b1.C, b1.V} !== 4'b0100)
      $display("FAIL asr_iter got %h %b want 3c0 0100", res1, {b1.Z, b1.N, b1.C, b1.V});
    else n_pass++;
  endtask

  task automatic test_lsl_clamp;
    int cnt;
    load_a(1); gin_op(9, 12);
    n_chk++;
    if (res0 !== 10'h000 || {b0.Z, b0.N, b0.C, b0.V} !== 4'b1010 || b0.Busy !== 1'b0)
      $display("FAIL lsl_barrel got %h %b busy=%b want 000 1010 0", res0, {b0.Z, b0.N, b0.C, b0.V}, b0.Busy);
    else n_pass++;
    cnt = 0;
    while (b1.Busy && cnt < 40) begin cnt++; tick; end
    n_chk++;
    if (cnt !== 10) $display("FAIL lsl_busy_cycles got %0d want 10", cnt);
    else n_pass++;
    n_chk++;
    if (res1 !== 10'h000 || {b1.Z, b1.N, b1.C, b1.V} !== 4'b1010)
      $display("FAIL lsl_iter got %h %b want 000 1010", res1, {b1.Z, b1.N, b1.C, b1.V});
    else n_pass++;
  endtask

  task automatic test_rst_mid_shift;
    load_a(3); gin_op(3, 5);  // G=3FE, N=1 so the reset has visible effect
    gin_op(9, 5);
    tick;                     // second busy cycle
    Rst = 1; tick; Rst = 0;
    n_chk++;
    if (b1.Busy !== 1'b0 || res1 !== '0 || {b1.Z, b1.N, b1.C, b1.V} !== 4'b0000)
      $display("FAIL rst_abort got busy=%b %h %b want 0 000 0000", b1.Busy, res1, {b1.Z, b1.N, b1.C, b1.V});
    else n_pass++;
    tick;
    n_chk++;
    if (b1.Busy !== 1'b0) $display("FAIL rst_stays_idle got busy=%b want 0", b1.Busy);
    else n_pass++;
    load_a(10'h010); gin_op(12, 10'h3C5);
    n_chk++;
    if (res1 !== 10'h015 || {b1.Z, b1.N, b1.C, b1.V} !== 4'b0000)
      $display("FAIL addi_imm got %h %b want 015 0000", res1, {b1.Z, b1.N, b1.C, b1.V});
    else n_pass++;
  endtask

  task automatic test_random;
    int fn, op, f, n, cnt, r;
    bit c, v, ain, iter;
    Rst = 1; drive(0, 0, 0, 0); tick; Rst = 0;
    mA = 0; mG = 0; mZ = 0; mN = 0; mC = 0; mV = 0;
    for (int k = 0; k < 60; k++) begin
      r = $urandom_range(0, MASK);
      load_a(r); mA = r;
      fn = $urandom_range(0, 15);
      if (fn >= 9 && fn <= 11)
        op = ($urandom_range(0, 4) == 0) ? $urandom_range(0, MASK) : $urandom_range(0, W + 2);
      else
        op = $urandom_range(0, MASK);
      ain = ($urandom_range(0, 1) == 1);
      drive(ain, 1, fn, op); tick; drive(0, 0, 0, 0);
      iter = (fn >= 9 && fn <= 11) && (op > 0);
      n = (op > W) ? W : op;
      if (fn < 14) begin
        ref_op(fn, mA, op, f, c, v);
        mG = f; mZ = (f == 0); mN = ((f >> (W-1)) & 1) != 0; mC = c; mV = v;
      end
      if (ain) mA = op;
      n_chk++;
      if (res0 !== W'(mG) || {b0.Z, b0.N, b0.C, b0.V} !== {mZ, mN, mC, mV} || b0.Busy !== 1'b0)
        $display("FAIL rand_barrel fn=%0d op=%h got %h %b busy=%b want %h %b", fn, op, res0,
                 {b0.Z, b0.N, b0.C, b0.V}, b0.Busy, W'(mG), {mZ, mN, mC, mV});
      else n_pass++;
      cnt = 0;
      if (iter) begin
        while (b1.Busy && cnt < 40) begin
          cnt++;
          r = $urandom_range(0, MASK);
          if ($urandom_range(0, 2) == 0) begin drive(1, 0, 0, r); mA = r; end
          tick; drive(0, 0, 0, 0);
        end
      end
      n_chk++;
      if (cnt !== (iter ? n : 0) || b1.Busy !== 1'b0)
        $display("FAIL rand_busy fn=%0d op=%h got %0d busy=%b want %0d", fn, op, cnt, b1.Busy, iter ? n : 0);
      else n_pass++;
      n_chk++;
      if (res1 !== W'(mG) || {b1.Z, b1.N, b1.C, b1.V} !== {mZ, mN, mC, mV})
        $display("FAIL rand_iter fn=%0d op=%h got %h %b want %h %b", fn, op, res1,
                 {b1.Z, b1.N, b1.C, b1.V}, W'(mG), {mZ, mN, mC, mV});
      else n_pass++;
    end
    // A loaded during the last operations must have landed in both instances.
    gin_op(1, 0); gin_op(2, 0);
    n_chk++;
    if (res1 !== W'(mA) || res0 !== W'(mA))
      $display("FAIL rand_final_a got %h/%h want %h", res1, res0, W'(mA));
    else n_pass++;
  endtask

  initial begin
    set_gout(1);
    drive(0, 0, 0, 0);
    test_reset;
    test_add;
    test_sub_inv;
    test_asr_iter;
    test_lsl_clamp;
    test_rst_mid_shift;
    test_random;
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
